// File: rtl/resampler_pkg.sv
// Shared definitions for the resampler output chain and its req/ack stages.
// Latency: none (types, constants and a constant function only).
// Backpressure: n/a.
// Contents: default sample width, four-phase handshake state encoding,
// log2 helper for FIFO and counter sizing.
package resampler_pkg;

   localparam int DEF_DWIDTH = 16;

   // Four-phase req/ack handshake: IDLE waits for req, ACK waits for req to drop.
   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } hs_state_t;

   // Ceiling log2, usable in parameter defaults.
   function automatic int log2_ceil(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/i2s_serializer_if.sv
// Bundle of the serializer's producer handshake and DAC-side serial outputs.
// Latency: none (wiring only).
// Backpressure: ack_in is withheld by the serializer while its FIFO is full.
// Ports: req_in/data_in (producer -> serializer), ack_in, bclk, lrclk, sdata,
// underrun, fifo_level (serializer -> outside). slave = serializer side.
interface i2s_serializer_if
   import resampler_pkg::*;
#(
   parameter int DWIDTH   = DEF_DWIDTH,
   parameter int FIFO_LOG = 2
);
   logic                req_in;
   logic                ack_in;
   logic [0:DWIDTH-1]   data_in;   // bit 0 is the MSB
   logic                bclk;
   logic                lrclk;
   logic                sdata;
   logic                underrun;
   logic [FIFO_LOG:0]   fifo_level;

   modport master (
      output req_in, data_in,
      input  ack_in, bclk, lrclk, sdata, underrun, fifo_level
   );

   modport slave (
      input  req_in, data_in,
      output ack_in, bclk, lrclk, sdata, underrun, fifo_level
   );
endinterface

// File: rtl/sample_fifo.sv
// Small sample FIFO between the input handshake and the frame shifter.
// Latency: write visible at the head one clk later; rd_dat is the current head (comb).
// Backpressure: full/empty only; the caller must not write when full or pop when empty.
// Ports: clk, rst (async, active-high), wr_en/wr_dat, rd_en/rd_dat, full, empty, level.
module sample_fifo
   import resampler_pkg::*;
#(
   parameter int DWIDTH     = DEF_DWIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_LOG   = log2_ceil(FIFO_DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [0:DWIDTH-1]   wr_dat,
   input  logic                rd_en,
   output logic [0:DWIDTH-1]   rd_dat,
   output logic                full,
   output logic                empty,
   output logic [FIFO_LOG:0]   level
);
   logic [0:DWIDTH-1]   mem_q [FIFO_DEPTH];
   logic [FIFO_LOG-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_LOG-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_LOG:0]   level_q, level_d;

   // Power-of-2 depth: pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: contents are meaningless once the pointers clear.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_dat;
      end
   end

   assign rd_dat = mem_q[rd_ptr_q];
   assign full   = (level_q == (FIFO_LOG+1)'(FIFO_DEPTH));
   assign empty  = (level_q == '0);
   assign level  = level_q;

endmodule

// File: rtl/i2s_serializer.sv
// Mono-to-stereo left-justified serializer: req/ack input, FIFO, bclk/lrclk/sdata out.
// Latency: ack 1 clk after req sampled with space; sample leaves at the next frame start.
// Backpressure: ack_in withheld while the FIFO is full; req_in simply waits.
// Ports: clk, rst (async, active-high), bus (i2s_serializer_if.slave).
// Option: I2S_SERIALIZER_HOLD_LAST_EN repeats the last popped sample on underrun
// instead of sending zeros.
module i2s_serializer
   import resampler_pkg::*;
#(
   parameter int DWIDTH     = DEF_DWIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_LOG   = log2_ceil(FIFO_DEPTH),
   parameter int BCLK_DIV   = 4
) (
   input logic              clk,
   input logic              rst,
   i2s_serializer_if.slave  bus
);
   localparam int DIVW = log2_ceil(BCLK_DIV);
   localparam int BW   = log2_ceil(2 * DWIDTH);
   localparam int IW   = log2_ceil(DWIDTH);
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_DIV - 1);
   localparam logic [BW-1:0]   BIT_LAST = BW'(2 * DWIDTH - 1);
   localparam logic [BW-1:0]   SLOT_LEN = BW'(DWIDTH);

   hs_state_t           hs_state_q;
   logic                ack_q;

   logic                fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
   logic [0:DWIDTH-1]   fifo_rd_dat;
   logic [FIFO_LOG:0]   fifo_level;

   logic [DIVW-1:0]     div_cnt_q, div_cnt_d;
   logic                bclk_q, bclk_d;
   logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [0:DWIDTH-1]   sreg_q, sreg_d;
   logic                sdata_q, sdata_d;
   logic                lrclk_q, lrclk_d;
   logic                underrun_q, underrun_d;
`ifdef I2S_SERIALIZER_HOLD_LAST_EN
   logic [0:DWIDTH-1]   last_q, last_d;
`endif

   logic                div_last, shift_evt, frame_start;
   logic [BW-1:0]       slot_off;
   logic [IW-1:0]       bit_idx;

   // ---------------- input handshake ----------------
   assign fifo_wr_en = (hs_state_q == IDLE) && bus.req_in && !fifo_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_state_q <= IDLE;
         ack_q      <= 1'b0;
      end else begin
         case (hs_state_q)
            IDLE: if (fifo_wr_en) begin
               hs_state_q <= ACK;
               ack_q      <= 1'b1;
            end
            ACK: if (!bus.req_in) begin
               hs_state_q <= IDLE;
               ack_q      <= 1'b0;
            end
            default: begin
               hs_state_q <= IDLE;
               ack_q      <= 1'b0;
            end
         endcase
      end
   end

   sample_fifo #(
      .DWIDTH     (DWIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .FIFO_LOG   (FIFO_LOG)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (fifo_wr_en),
      .wr_dat (bus.data_in),
      .rd_en  (fifo_rd_en),
      .rd_dat (fifo_rd_dat),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (fifo_level)
   );

   // ---------------- bit clock and frame shifter ----------------
   // A shift event is the clk edge where bclk falls; outputs for bit_cnt are
   // registered on that same edge, so lrclk and the slot MSB change together.
   assign div_last    = (div_cnt_q == DIV_LAST);
   assign shift_evt   = div_last && bclk_q;
   assign frame_start = shift_evt && (bit_cnt_q == '0);
   assign fifo_rd_en  = frame_start && !fifo_empty;

   // Bit position inside the current slot; both slots index the same sample.
   assign slot_off = (bit_cnt_q >= SLOT_LEN) ? bit_cnt_q - SLOT_LEN : bit_cnt_q;
   assign bit_idx  = slot_off[IW-1:0];

   always_comb begin
      div_cnt_d  = div_last ? '0 : div_cnt_q + 1'b1;
      bclk_d     = div_last ? ~bclk_q : bclk_q;
      bit_cnt_d  = bit_cnt_q;
      sreg_d     = sreg_q;
      sdata_d    = sdata_q;
      lrclk_d    = lrclk_q;
      underrun_d = 1'b0;
`ifdef I2S_SERIALIZER_HOLD_LAST_EN
      last_d     = fifo_rd_en ? fifo_rd_dat : last_q;
`endif
      if (shift_evt) begin
         bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
         lrclk_d   = (bit_cnt_q >= SLOT_LEN);
         if (frame_start) begin
            if (fifo_empty) begin
               underrun_d = 1'b1;
`ifdef I2S_SERIALIZER_HOLD_LAST_EN
               sreg_d     = last_q;
`else
               sreg_d     = '0;
`endif
            end else begin
               sreg_d = fifo_rd_dat;
            end
            sdata_d = sreg_d[0];
         end else begin
            sdata_d = sreg_q[bit_idx];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q  <= '0;
         bclk_q     <= 1'b0;
         bit_cnt_q  <= '0;
         sreg_q     <= '0;
         sdata_q    <= 1'b0;
         lrclk_q    <= 1'b0;
         underrun_q <= 1'b0;
`ifdef I2S_SERIALIZER_HOLD_LAST_EN
         last_q     <= '0;
`endif
      end else begin
         div_cnt_q  <= div_cnt_d;
         bclk_q     <= bclk_d;
         bit_cnt_q  <= bit_cnt_d;
         sreg_q     <= sreg_d;
         sdata_q    <= sdata_d;
         lrclk_q    <= lrclk_d;
         underrun_q <= underrun_d;
`ifdef I2S_SERIALIZER_HOLD_LAST_EN
         last_q     <= last_d;
`endif
      end
   end

   assign bus.ack_in     = ack_q;
   assign bus.bclk       = bclk_q;
   assign bus.lrclk      = lrclk_q;
   assign bus.sdata      = sdata_q;
   assign bus.underrun   = underrun_q;
   assign bus.fifo_level = fifo_level;

endmodule

// File: tb/tb_i2s_serializer.sv
// Bench for i2s_serializer: directed handshakes plus a frame scoreboard.
// Latency: n/a.
// Backpressure: exercised by filling the FIFO ahead of a frame boundary.
module tb_i2s_serializer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   logic [15:0] exp_q[$];

   i2s_serializer_if #(.DWIDTH(16), .FIFO_LOG(2)) bus ();

   i2s_serializer #(
      .DWIDTH(16), .FIFO_DEPTH(4), .FIFO_LOG(2), .BCLK_DIV(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Clk edge number since reset release (edge 1 = first posedge after release).
   always @(posedge clk or posedge rst) begin
      if (rst) cyc = 0;
      else     cyc = cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v);
      int n;
      @(negedge clk);
      bus.req_in  = 1'b1;
      bus.data_in = v;
      n = 0;
      do begin tick(); n++; end while (!bus.ack_in && n < 50);
      chk("push_ack", bus.ack_in, 1);
      if (bus.ack_in) exp_q.push_back(v);
      @(negedge clk);
      bus.req_in = 1'b0;
      n = 0;
      do begin tick(); n++; end while (bus.ack_in && n < 50);
      chk("push_release", bus.ack_in, 0);
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin : monitor
      int mb;
      logic pb, lr_bad, exp_und;
      logic [15:0] cur, fl, fr, mlast;
      mb = 0; pb = 1'b0; lr_bad = 1'b0; cur = '0; fl = '0; fr = '0; mlast = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mb = 0; pb = 1'b0; mlast = '0;
            continue;
         end
         if (pb && !bus.bclk) begin
            if (mb == 0) begin
               exp_und = (exp_q.size() == 0);
               if (exp_und) begin
`ifdef I2S_SERIALIZER_HOLD_LAST_EN
                  cur = mlast;
`else
                  cur = 16'h0000;
`endif
               end else begin
                  cur   = exp_q.pop_front();
                  mlast = cur;
               end
               chk("frame_underrun", bus.underrun, exp_und);
               lr_bad = 1'b0; fl = '0; fr = '0;
            end else if (bus.underrun) begin
               chk("stray_underrun", bus.underrun, 0);
            end
            if (bus.lrclk !== (mb >= 16)) lr_bad = 1'b1;
            if (mb < 16) fl = {fl[14:0], bus.sdata};
            else         fr = {fr[14:0], bus.sdata};
            if (mb == 31) begin
               chk("frame_left", fl, cur);
               chk("frame_right", fr, cur);
               chk("frame_lrclk_bad", lr_bad, 0);
               mb = 0;
            end else begin
               mb++;
            end
         end else if (bus.underrun) begin
            chk("stray_underrun", bus.underrun, 0);
         end
         pb = bus.bclk;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed stimulus ----------------
   initial begin : stim
      int ucnt;
      logic pre_bad;
      bus.req_in  = 1'b0;
      bus.data_in = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_ack", bus.ack_in, 0);
      chk("rst_bclk", bus.bclk, 0);
      chk("rst_lrclk", bus.lrclk, 0);
      chk("rst_sdata", bus.sdata, 0);
      chk("rst_underrun", bus.underrun, 0);
      chk("rst_level", bus.fifo_level, 0);

      // Single sample, request raised on release.
      rst = 1'b0;
      bus.req_in  = 1'b1;
      bus.data_in = 16'hA5C3;
      tick();  // edge 1
      chk("single_ack_rise", bus.ack_in, 1);
      chk("single_level1", bus.fifo_level, 1);
      if (bus.ack_in) exp_q.push_back(16'hA5C3);
      pre_bad = bus.sdata | bus.lrclk;
      @(negedge clk);
      bus.req_in = 1'b0;
      tick();  // edge 2
      chk("single_ack_fall", bus.ack_in, 0);
      for (int e = 3; e <= 8; e++) begin
         tick();
         if (e < 8) pre_bad = pre_bad | bus.sdata | bus.lrclk;
         if (e == 3) chk("bclk_e3", bus.bclk, 0);
         if (e == 4) chk("bclk_e4", bus.bclk, 1);
         if (e == 7) begin
            chk("bclk_e7", bus.bclk, 1);
            chk("level_e7", bus.fifo_level, 1);
         end
         if (e == 8) begin
            chk("bclk_e8", bus.bclk, 0);
            chk("level_e8", bus.fifo_level, 0);
            chk("sdata_e8_msb", bus.sdata, 1);
         end
      end
      chk("pre_shift_quiet", pre_bad, 0);

      // Three idle frames: exactly one underrun pulse per 256 clks.
      while (cyc < 260) tick();
      ucnt = 0;
      for (int i = 0; i < 768; i++) begin
         tick();
         if (bus.underrun) ucnt++;
      end
      chk("underrun_count", ucnt, 3);

      // Backpressure: fill before frame start 1288, fifth request waits for the pop.
      while (cyc < 1036) tick();
      push(16'h7FFF);
      push(16'h8001);
      push(16'h1234);
      push(16'hFFFF);
      @(negedge clk);
      bus.req_in  = 1'b1;
      bus.data_in = 16'h5AA5;
      while (cyc < 1287) tick();
      chk("bp_ack_held", bus.ack_in, 0);
      chk("bp_level_full", bus.fifo_level, 4);
      tick();  // 1288: pop
      chk("bp_level_pop", bus.fifo_level, 3);
      chk("bp_ack_pop_edge", bus.ack_in, 0);
      tick();  // 1289
      chk("bp_ack_rise", bus.ack_in, 1);
      chk("bp_level_refill", bus.fifo_level, 4);
      if (bus.ack_in) exp_q.push_back(16'h5AA5);
      @(negedge clk);
      bus.req_in = 1'b0;
      tick();
      chk("bp_ack_fall", bus.ack_in, 0);

      // Write lands on the frame-start pop at 2056 with level 2.
      while (cyc < 2055) tick();
      @(negedge clk);
      bus.req_in  = 1'b1;
      bus.data_in = 16'h3C7E;
      tick();  // 2056
      chk("simul_ack", bus.ack_in, 1);
      chk("simul_level", bus.fifo_level, 2);
      if (bus.ack_in) exp_q.push_back(16'h3C7E);
      @(negedge clk);
      bus.req_in = 1'b0;
      tick();

      // Reset mid-frame (3C7E frame started at 2568, bit_cnt=10) with ack high.
      while (cyc < 2638) tick();
      @(negedge clk);
      bus.req_in  = 1'b1;
      bus.data_in = 16'hDEAD;
      while (cyc < 2644) tick();
      chk("mid_ack_pre", bus.ack_in, 1);
      chk("mid_bclk_pre", bus.bclk, 1);
      chk("mid_sdata_pre", bus.sdata, 1);
      chk("mid_level_pre", bus.fifo_level, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_ack_rst", bus.ack_in, 0);
      chk("mid_bclk_rst", bus.bclk, 0);
      chk("mid_lrclk_rst", bus.lrclk, 0);
      chk("mid_sdata_rst", bus.sdata, 0);
      chk("mid_level_rst", bus.fifo_level, 0);
      bus.req_in = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push(16'hC0DE);
      while (cyc < 270) tick();
      chk("drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2s_serializer.md
Name: i2s_serializer

Overview:
- Downstream consumer of the 160/147 polyphase resampler.
- Accepts mono 16-bit samples over the resampler's four-phase req/ack output handshake.
- Buffers the samples in a small FIFO.
- Shifts each sample out MSB-first as a left-justified stereo serial stream (bclk, lrclk, sdata) to the DAC, with the mono sample duplicated into the left and right slots.

Parameters:
- DWIDTH, 16, sample width; frame = 2*DWIDTH bclk periods.
- FIFO_DEPTH, 4, sample buffer entries; must be a power of 2.
- FIFO_LOG, 2, log2(FIFO_DEPTH).
- BCLK_DIV, 4, clk cycles per bclk half-period; must be ≥2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- req_in  input  1  producer request; data_in valid while high.
- ack_in  output  1  acknowledge to producer.
- data_in  input  DWIDTH  signed sample; [0:DWIDTH-1] vector, bit 0 = MSB.
- bclk  output  1  serial bit clock.
- lrclk  output  1  0 = left slot, 1 = right slot.
- sdata  output  1  serial data, MSB first.
- underrun  output  1  one-clk pulse when a frame starts with the FIFO empty.
- fifo_level  output  FIFO_LOG+1  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Clocking and reset: one clock domain (clk); asynchronous active-high reset (rst). While rst is high, all of the following are 0:
  - outputs: ack_in, bclk, lrclk, sdata, underrun, fifo_level;
  - internal state: FIFO pointers, div_cnt, bit_cnt, shift register, handshake FSM (IDLE).
  - A reset mid-frame or mid-handshake aborts immediately; the partially sent frame and FIFO contents are discarded.
- Input handshake FSM:
  - IDLE, ack_in=0: when req_in=1 and FIFO not full, write data_in to the FIFO and set ack_in=1 on the next edge; go to ACK.
  - IDLE with FIFO full: ack is withheld and req_in waits.
  - ACK, ack_in=1: hold until req_in=0 is sampled, then ack_in=0 on the next edge; go to IDLE.
  - Exactly one write per handshake.
  - Latency: ack_in rises 1 clk after req_in is first sampled with space available.
- Bit clock:
  - div_cnt counts 0..BCLK_DIV-1; bclk toggles when div_cnt==BCLK_DIV-1.
  - A shift event is the clk edge on which bclk goes 1→0, once every 2*BCLK_DIV clks.
  - The first shift event after reset is at clk edge 2*BCLK_DIV.
- Frame sequencing:
  - bit_cnt counts 0..2*DWIDTH-1 and advances on each shift event.
  - On a shift event with bit_cnt==0, pop the FIFO head into the shift register.
  - If the FIFO is empty at that event, load 0 and pulse underrun for 1 clk.
  - sdata = shift register bit (bit_cnt mod DWIDTH); the same sample is sent in both slots.
  - lrclk = 0 for bit_cnt 0..DWIDTH-1 and 1 otherwise; it changes on the same shift event as the slot's MSB (left-justified, no 1-bit delay).
  - Before the first shift event: sdata=0, lrclk=0.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH.
  - A write and a pop on the same edge are both performed; fifo_level is unchanged.
  - A write while full is impossible by construction because ack is withheld.
  - fifo_level is registered and updates on the same edge as the write or pop.
- Throughput: one sample per 2*DWIDTH*2*BCLK_DIV clks (256 at defaults).

Optional Feature:
- Macro: I2S_SERIALIZER_HOLD_LAST_EN.
- Defined: on underrun, the shift register reloads the last successfully popped sample (0 if none since reset); the underrun pulse still fires.
- Undefined: on underrun, zeros are transmitted.

Decomposition:
- Shared package resampler_pkg holds:
  - default DWIDTH;
  - handshake FSM state encoding (IDLE, ACK), also reusable by future req/ack stages;
  - a function computing log2 for FIFO sizing.
- Sub-module sample_fifo (parameters DWIDTH, FIFO_DEPTH, FIFO_LOG): synchronous write and pop, with full, empty and level outputs.
- Handshake FSM, divider and shifter stay in the top.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; bclk first rises at clk edge 4 after release, first shift event at clk edge 8.
- Single sample: push 16'hA5C3 (req_in held until ack_in) -> ack_in high 1 clk after req sampled, low 1 clk after req drops; the frame starting at clk 8 gives sdata = 1010010111000011 with lrclk=0, then the same 16 bits with lrclk=1; fifo_level 1→0 at clk 8.
- Backpressure: push 4 samples before clk 8, then raise req for a 5th -> ack_in withheld (fifo_level=4) until the pop at clk 8; ack_in rises on the next clk.
- Underrun: no input for 3 frames -> sdata constantly 0, underrun pulses exactly once every 256 clks. With I2S_SERIALIZER_HOLD_LAST_EN after a prior 16'h7FFF -> 16'h7FFF repeated in every slot.
- Simultaneous events: write handshake completing on the same edge as a frame-start pop with level=2 -> level stays 2 and the popped sample is the oldest.
- Reset mid-frame: assert rst at bit_cnt=10 with ack_in=1 -> ack_in, bclk, lrclk and sdata drop to 0 immediately; after release the first frame transmits a newly pushed sample, never stale data.
